// File: rtl/repeater_pkg.sv
// Shared definitions for the repeater stream arbiter: default width, FSM
// state encoding and the channel-id width helper.
package repeater_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic ARB   = 1'b0;
  localparam logic GRANT = 1'b1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping circularly, found by masking a doubled request vector.
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              any,
  output logic [ID_W-1:0]   idx
);

  logic [2*NUM_CH-1:0] dbl;
  logic [2*NUM_CH-1:0] masked;
  logic                found;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    found  = 1'b0;
    idx    = '0;
    any    = |req;
    // Lower copy keeps only positions >= ptr; upper copy supplies the wrap.
    for (int i = 0; i < 2*NUM_CH; i++) begin
      masked[i] = dbl[i] && ((i >= NUM_CH) || (i >= int'(ptr)));
    end
    for (int i = 0; i < 2*NUM_CH; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = ID_W'(i % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/repeater_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered AXI-stream
// datapath between NUM_CH requesters; grants end on tlast or MAX_BURST words.
module repeater_stream_arbiter
  import repeater_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_CH    = 2,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = id_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          m_tid,
  output logic                     m_tvalid,
  input  logic                     m_tready
);

  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  // Handshake: a beat moves on tvalid && tready at the rising clk edge;
  // m_* hold steady while m_tvalid is high and m_tready is low.
  logic              state, next_state;
  logic [ID_W-1:0]   grant, rr_ptr;
  logic [CNT_W-1:0]  burst_cnt;
  logic              ld, pick_any, accept, cap_hit, beat_last;
  logic [ID_W-1:0]   pick_idx;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_rr_pick (
    .req (s_tvalid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    ld        = ~m_tvalid | m_tready;
    sel_data  = s_tdata[int'(grant)*DATA_W +: DATA_W];
    accept    = (state == GRANT) && s_tvalid[grant] && ld;
    cap_hit   = (MAX_BURST != 0) && (int'(burst_cnt) == MAX_BURST - 1);
    beat_last = s_tlast[grant] | cap_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB:     if (pick_any) next_state = GRANT;
      GRANT:   if (accept && beat_last) next_state = ARB;
      default: next_state = ARB;
    endcase
  end

  always_comb begin
    s_tready = '0;
    if (state == GRANT && ld) s_tready[grant] = 1'b1;
  end

  // Grant bookkeeping: pointer moves past the winner only when its grant ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (state == ARB) begin
      if (pick_any) begin
        grant     <= pick_idx;
        burst_cnt <= '0;
      end
    end else if (accept) begin
      if (beat_last) begin
        rr_ptr    <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= sel_data;
      m_tlast  <= beat_last;
      m_tid    <= grant;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule
